// File: rtl/axis_stage_scheduler.sv
// Sequences a chain of AXI-Stream buffer stages for one CNN inference:
// start handshake per stage, wait for its last beat, then move on.
module axis_stage_scheduler #(
    parameter int NUMSTAGES = 3,
    parameter int TIMEOUT   = 4096,
    parameter int CNTWIDTH  = 16,
    localparam int SW = (NUMSTAGES > 2) ? $clog2(NUMSTAGES) : 1,
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 err_clr,
    output logic [NUMSTAGES-1:0] stage_start,
    input  logic [NUMSTAGES-1:0] stage_startAck,
    input  logic [NUMSTAGES-1:0] stage_mLast,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [SW-1:0]        cur_stage,
    output logic [CNTWIDTH-1:0]  frame_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        REL,
        RUN,
        NEXT,
        DONE,
        ERR
    } state_t;

    localparam logic [SW-1:0] LAST = SW'(NUMSTAGES - 1);
    localparam logic [TW-1:0] TLIM = TW'(TIMEOUT - 1);

    state_t               state;
    logic [SW-1:0]        k;
    logic [TW-1:0]        tcnt;
    logic                 err_q;
    logic [CNTWIDTH-1:0]  frames;
    logic                 ack_k;
    logic                 mlast_k;

    // Only the active stage's handshake inputs are ever looked at.
    assign ack_k   = stage_startAck[k];
    assign mlast_k = stage_mLast[k];

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            k      <= '0;
            tcnt   <= '0;
            err_q  <= 1'b0;
            frames <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (go) begin
                        state <= REQ;
                        k     <= '0;
                    end
                end
                REQ: begin
                    if (ack_k) state <= REL;
                end
                REL: begin
                    if (!ack_k) begin
                        state <= RUN;
                        tcnt  <= '0;
                    end
                end
                RUN: begin
                    // A last beat on the final allowed cycle still counts.
                    if (mlast_k) begin
                        state <= NEXT;
                    end else if (tcnt == TLIM) begin
                        state <= ERR;
                        err_q <= 1'b1;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                NEXT: begin
                    if (k == LAST) begin
                        state <= DONE;
                    end else begin
                        k     <= k + 1'b1;
                        state <= REQ;
                    end
                end
                DONE: begin
                    frames <= frames + 1'b1;
                    k      <= '0;
                    state  <= IDLE;
                end
                ERR: begin
                    if (err_clr) begin
                        err_q <= 1'b0;
                        k     <= '0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign stage_start = (state == REQ) ? (NUMSTAGES'(1) << k) : '0;
    assign busy        = (state != IDLE) && (state != ERR);
    assign done        = (state == DONE);
    assign error       = err_q;
    assign cur_stage   = k;
    assign frame_cnt   = frames;

endmodule

// File: tb/tb_axis_stage_scheduler.sv
// Self-checking bench for axis_stage_scheduler: behavioural stage
// responders plus a cycle-timeline model of each inference.
module tb_axis_stage_scheduler;

    localparam int NS = 3;
    localparam int TO = 16;
    localparam int CW = 2;
    localparam int SW = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          go;
    logic          err_clr;
    logic [NS-1:0] stage_start;
    logic [NS-1:0] ack;
    logic [NS-1:0] mlast;
    logic          busy;
    logic          done;
    logic          error;
    logic [SW-1:0] cur_stage;
    logic [CW-1:0] frame_cnt;

    axis_stage_scheduler #(
        .NUMSTAGES(NS),
        .TIMEOUT  (TO),
        .CNTWIDTH (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .go            (go),
        .err_clr       (err_clr),
        .stage_start   (stage_start),
        .stage_startAck(ack),
        .stage_mLast   (mlast),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .cur_stage     (cur_stage),
        .frame_cnt     (frame_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int frames = 0;
    int ad[NS];
    int md[NS];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Stage k with ack delay a and last-beat delay m occupies a+m+4 cycles;
    // a stage with m >= TO times out TO cycles into its run phase.
    task automatic run_inf(input bit hold, input int rst_at);
        int  sstart[NS];
        int  hi[NS];
        int  acnt[NS];
        int  rcnt[NS];
        bit  running[NS];
        int  exp_start[NS];
        int  base, exp_done, err_stg, exp_err, limit, cur;
        int  done_t, err_t;
        bit  onehot_ok, busy_ok, excl_ok, stg_ok, fin, err_busy;
        base = 1;
        err_stg = -1;
        exp_err = 0;
        for (int k = 0; k < NS; k++) begin
            exp_start[k] = base;
            if (err_stg < 0 && md[k] >= TO) begin
                err_stg = k;
                exp_err = base + ad[k] + 2 + TO;
            end
            base += ad[k] + md[k] + 4;
            sstart[k] = -1;
            hi[k] = 0;
            acnt[k] = 0;
            rcnt[k] = 0;
            running[k] = 1'b0;
        end
        exp_done = base;
        limit = ((err_stg >= 0) ? exp_err : exp_done) + 8;
        cur = 0;
        done_t = -1;
        err_t = -1;
        err_busy = 1'b1;
        onehot_ok = 1'b1;
        busy_ok = 1'b1;
        excl_ok = 1'b1;
        stg_ok = 1'b1;
        fin = 1'b0;
        ack = '0;
        mlast = '0;
        go = 1'b1;
        @(negedge clk);
        if (!hold) go = 1'b0;
        for (int t = 1; t <= limit && !fin; t++) begin
            if (rst_at != 0 && t == rst_at) begin
                go = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                ack = '0;
                mlast = '0;
                frames = 0;
                chk("rst_start", 32'(stage_start), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_cur", 32'(cur_stage), 0);
                chk("rst_frames", 32'(frame_cnt), 0);
                chk("rst_error", 32'(error), 0);
                return;
            end
            if ($countones(stage_start) > 1) onehot_ok = 1'b0;
            if (done && stage_start != '0) excl_ok = 1'b0;
            if (!error && !busy) busy_ok = 1'b0;
            for (int j = 0; j < NS; j++) begin
                if (stage_start[j]) begin
                    if (sstart[j] < 0) sstart[j] = t;
                    hi[j]++;
                    cur = j;
                end
            end
            if (busy && int'(cur_stage) != cur) stg_ok = 1'b0;
            if (done) begin
                done_t = t;
                fin = 1'b1;
            end
            if (error) begin
                err_t = t;
                err_busy = busy;
                fin = 1'b1;
            end
            mlast = '0;
            for (int j = 0; j < NS; j++) begin
                if (stage_start[j]) begin
                    if (acnt[j] == ad[j]) ack[j] = 1'b1;
                    else acnt[j]++;
                end else if (ack[j]) begin
                    ack[j] = 1'b0;
                    running[j] = 1'b1;
                    rcnt[j] = 0;
                end else if (running[j]) begin
                    rcnt[j]++;
                    if (rcnt[j] == md[j] + 1) begin
                        mlast[j] = 1'b1;
                        running[j] = 1'b0;
                    end
                end
            end
            for (int j = 0; j < NS; j++)
                if (j != cur && $urandom_range(0, 1) == 1) mlast[j] = 1'b1;
            @(negedge clk);
        end
        mlast = '0;
        ack = '0;
        chk("onehot", 32'(onehot_ok), 1);
        chk("done_excl", 32'(excl_ok), 1);
        chk("busy_run", 32'(busy_ok), 1);
        chk("cur_track", 32'(stg_ok), 1);
        if (err_stg < 0) begin
            for (int k = 0; k < NS; k++) begin
                chk($sformatf("start_t%0d", k), 32'(sstart[k]), 32'(exp_start[k]));
                chk($sformatf("start_len%0d", k), 32'(hi[k]), 32'(ad[k] + 1));
            end
            frames = (frames + 1) % (1 << CW);
            chk("done_t", 32'(done_t), 32'(exp_done));
            chk("done_pulse", 32'(done), 0);
            chk("frame_cnt", 32'(frame_cnt), 32'(frames));
            chk("idle_busy", 32'(busy), 0);
            chk("idle_cur", 32'(cur_stage), 0);
        end else begin
            for (int k = 0; k <= err_stg; k++)
                chk($sformatf("start_t%0d", k), 32'(sstart[k]), 32'(exp_start[k]));
            chk("err_t", 32'(err_t), 32'(exp_err));
            chk("err_busy", 32'(err_busy), 0);
            chk("err_cur", 32'(cur_stage), 32'(err_stg));
            chk("err_sticky", 32'(error), 1);
            go = 1'b1;
            @(negedge clk);
            go = 1'b0;
            chk("err_go_ign", 32'(error), 1);
            chk("err_go_start", 32'(stage_start), 0);
            err_clr = 1'b1;
            @(negedge clk);
            err_clr = 1'b0;
            chk("clr_error", 32'(error), 0);
            chk("clr_busy", 32'(busy), 0);
            chk("clr_cur", 32'(cur_stage), 0);
            chk("clr_frames", 32'(frame_cnt), 32'(frames));
        end
    endtask

    initial begin
        rst = 1'b1;
        go = 1'b0;
        err_clr = 1'b0;
        ack = '0;
        mlast = '0;
        repeat (3) @(negedge clk);
        chk("reset_start", 32'(stage_start), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_error", 32'(error), 0);
        chk("reset_cur", 32'(cur_stage), 0);
        chk("reset_frames", 32'(frame_cnt), 0);
        rst = 1'b0;
        @(negedge clk);

        ad = '{1, 1, 1};
        md = '{10, 10, 10};
        run_inf(1'b0, 0);

        ad = '{0, 49, 0};
        md = '{3, 3, 3};
        run_inf(1'b0, 0);

        ad = '{0, 0, 0};
        md = '{0, 0, 0};
        run_inf(1'b0, 0);

        ad = '{0, 0, 1};
        md = '{2, 5, 1000};
        run_inf(1'b0, 0);

        ad = '{int'($urandom_range(0, 3)), 2, 0};
        md = '{15, 14, 15};
        run_inf(1'b0, 0);

        ad = '{0, 0, 0};
        md = '{5, 8, 5};
        run_inf(1'b0, 14);
        @(negedge clk);

        for (int n = 0; n < 5; n++) begin
            for (int k = 0; k < NS; k++) begin
                ad[k] = $urandom_range(0, 3);
                md[k] = $urandom_range(0, 15);
            end
            run_inf(1'b1, 0);
        end
        go = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 6; n++) begin
            for (int k = 0; k < NS; k++) begin
                ad[k] = $urandom_range(0, 4);
                md[k] = ($urandom_range(0, 7) == 0) ? 100 : $urandom_range(0, 15);
            end
            run_inf(1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
